// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: captures each rx_done word into a small FIFO, keeps
// a separate last-received register and a sticky overrun flag for dropped writes.
module uart_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              pclk,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] rx_data_i,
   input  logic              rx_done_i,
   input  logic              rd_en_i,
   input  logic              ovr_clr_i,
   output logic [DATA_W-1:0] dout_o,
   output logic              dout_valid_o,
   output logic [DATA_W-1:0] last_data_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [ADDR_W:0]   count_o,
   output logic              overrun_o
);

   localparam logic [ADDR_W:0] DEPTH_C = ADDR_W'(DEPTH) == '0 ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic [DATA_W-1:0] last_data_q, last_data_d;
   logic              overrun_q, overrun_d;

   logic empty, full, wr_acc, rd_acc, ovr_evt;

   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_C);

   // When full, a same-cycle read frees the slot the write lands in.
   assign rd_acc  = rd_en_i && !empty;
   assign wr_acc  = rx_done_i && (!full || rd_en_i);
   assign ovr_evt = rx_done_i && full && !rd_en_i;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      last_data_d  = last_data_q;
      overrun_d    = overrun_q;

      if (wr_acc)
         wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) begin
         rd_ptr_d     = rd_ptr_q + 1'b1;
         dout_d       = mem_q[rd_ptr_q];
         dout_valid_d = 1'b1;
      end
      if (wr_acc && !rd_acc)
         count_d = count_q + 1'b1;
      else if (rd_acc && !wr_acc)
         count_d = count_q - 1'b1;

      if (rx_done_i)
         last_data_d = rx_data_i;

      // Set has priority over clear.
      if (ovr_evt)
         overrun_d = 1'b1;
      else if (ovr_clr_i)
         overrun_d = 1'b0;
   end

   always_ff @(posedge pclk) begin
      if (rst_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         last_data_q  <= '0;
         overrun_q    <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         last_data_q  <= last_data_d;
         overrun_q    <= overrun_d;
      end
   end

   always_ff @(posedge pclk) begin
      if (!rst_i && wr_acc)
         mem_q[wr_ptr_q] <= rx_data_i;
   end

   assign dout_o       = dout_q;
   assign dout_valid_o = dout_valid_q;
   assign last_data_o  = last_data_q;
   assign empty_o      = empty;
   assign full_o       = full;
   assign count_o      = count_q;
   assign overrun_o    = overrun_q;

endmodule
